hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_NO, default 32: number of architectural registers; register addresses are $clog2(REG_NO) bits (AW).
REQ-002 SHALL have parameter MEM_TO, default 16: maximum data-memory wait, in cycles, before timeout.
REQ-003 SHALL have parameter CNT_W, default 32: width of each event counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rs1_id, rs2_id  in  AW each  source registers of the instruction in ID.
REQ-007 rs1_ex, rs2_ex  in  AW each  source registers of the instruction in EX.
REQ-008 rd_ex, rd_me, rd_wb  in  AW each  destination registers in EX, ME and WB.
REQ-009 rs2_me  in  AW  store-data source register of the instruction in ME.
REQ-010 regwrite_ex, regwrite_me, regwrite_wb  in  1 each  register-write enables in EX, ME and WB.
REQ-011 memread_ex  in  1  the instruction in EX is a load.
REQ-012 branch_taken_ex  in  1  redirect resolved in EX.
REQ-013 mem_req_me, mem_ready_me  in  1 each  data-memory request and ready from ME.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand select: 0 register file, 1 WB result, 2 ME result.
REQ-015 fwd_sd  out  1  ME store data taken from the WB result.
REQ-016 stall_if, stall_id, stall_ex, stall_me  out  1 each  hold the named pipeline register.
REQ-017 flush_id, flush_ex  out  1 each  replace the ID/EX contents with a bubble.
REQ-018 mem_timeout  out  1  one-cycle pulse when a memory wait is abandoned.
REQ-019 cnt_load_use, cnt_mem_wait, cnt_flush  out  CNT_W each  saturating event counters.

Function
REQ-020 fwd_a SHALL be 2 if regwrite_me is set, rd_me is not 0 and rd_me equals rs1_ex; else 1 under the same rule applied to WB (regwrite_wb, rd_wb); else 0. ME has priority over WB. fwd_b SHALL apply the same rule to rs2_ex.
REQ-021 fwd_sd SHALL be 1 when regwrite_wb is set, rd_wb is not 0 and rd_wb equals rs2_me.
REQ-022 load_use SHALL be true when memread_ex is set, rd_ex is not 0, and rd_ex equals rs1_id or rs2_id.
REQ-023 The FSM SHALL have two states, RUN and MEM_WAIT.
- RUN to MEM_WAIT when mem_req_me=1 and mem_ready_me=0.
- MEM_WAIT to RUN when mem_ready_me=1, or when the wait counter reaches MEM_TO-1.
REQ-024 mem_stall SHALL be (RUN and mem_req_me and not mem_ready_me) or (MEM_WAIT and not mem_ready_me and wait counter below MEM_TO-1).
- mem_stall=1 forces all four stall outputs to 1.
- mem_stall=1 forces both flush outputs to 0.
REQ-025 The wait counter SHALL clear on entry to MEM_WAIT and increment once per MEM_WAIT cycle.
- If it reaches MEM_TO-1 with mem_ready_me still 0: pulse mem_timeout for that cycle, deassert mem_stall in that cycle, and return to RUN.
REQ-026 pend_flush register: set when branch_taken_ex=1 and mem_stall=1; cleared on the first cycle with mem_stall=0.
REQ-027 With mem_stall=0 and (branch_taken_ex or pend_flush): flush_id=1, flush_ex=1, and no stall outputs. A redirect overrides load_use.
REQ-028 With mem_stall=0, no redirect and load_use: stall_if=1, stall_id=1, flush_ex=1, for exactly one cycle per hazard.
REQ-029 Counter increments:
- cnt_load_use: each cycle REQ-028 applies.
- cnt_mem_wait: each cycle mem_stall=1.
- cnt_flush: each cycle REQ-027 applies.
- Each counter saturates at its all-ones value.
REQ-030 Forwarding outputs SHALL be combinational and unaffected by stall state.

Reset
REQ-031 While rst_n=0, the following SHALL hold asynchronously:
- FSM = RUN; pend_flush = 0; wait counter = 0; all counters = 0; mem_timeout = 0.
- Stall and flush outputs = 0.
- Forwarding outputs follow their inputs combinationally.
REQ-032 Asserting reset during MEM_WAIT SHALL abandon the wait with no mem_timeout pulse.

Structure
REQ-033 A shared package hazard_pkg SHALL hold:
- the FSM state enum (RUN, MEM_WAIT);
- the fwd select constants FWD_RF=0, FWD_WB=1, FWD_ME=2.
REQ-034 Forwarding logic SHALL be a sub-module fwd_sel, instantiated twice (operands A and B); the REQ-021 store-data rule is a single-bit variant of the same logic inside hazard_ctrl.

Verification
REQ-035 rd_me=rd_wb=5, both regwrite set, rs1_ex=5 -> fwd_a=2; clear regwrite_me -> fwd_a=1; rd_me=rd_wb=0 -> fwd_a=0.
REQ-036 memread_ex=1, rd_ex=3, rs2_id=3 -> one cycle of stall_if=stall_id=flush_ex=1; cnt_load_use=1.
REQ-037 mem_req_me=1, mem_ready_me=0 for 4 cycles, then ready -> stall outputs high for 4 cycles; cnt_mem_wait=4; state back to RUN.
REQ-038 branch_taken_ex=1 during a memory stall -> flush_id=flush_ex=1 on the first cycle after ready rises; cnt_flush=1.
REQ-039 MEM_TO=16, ready held at 0 -> mem_timeout pulses once, after 16 stall cycles, and stalls drop.
REQ-040 rst_n low during MEM_WAIT -> all outputs and counters 0 at once; no timeout pulse.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller.
//   state_t  : memory-wait FSM states (RUN, MEM_WAIT)
//   FWD_*    : EX operand forwarding select codes
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'd0;  // operand from register file
    localparam logic [1:0] FWD_WB = 2'd1;  // operand from WB result
    localparam logic [1:0] FWD_ME = 2'd2;  // operand from ME result

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one EX source operand. The youngest in-flight writer
// (ME) wins over the older one (WB); register 0 is never forwarded.
//   rs                      : EX source register
//   rd_me, regwrite_me      : ME destination and write enable
//   rd_wb, regwrite_wb      : WB destination and write enable
//   sel                     : FWD_RF / FWD_WB / FWD_ME
// -----------------------------------------------------------------------------
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rd_me,
    input  logic          regwrite_me,
    input  logic [AW-1:0] rd_wb,
    input  logic          regwrite_wb,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (regwrite_me && (rd_me != '0) && (rd_me == rs)) begin
            sel = FWD_ME;
        end else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: operand / store-data forwarding, load-use
// stalls, redirect flushes and a data-memory wait FSM with timeout, plus
// saturating event counters.
//   clk, rst_n                       : clock, async active-low reset
//   rs1_id, rs2_id                   : ID sources (load-use detection)
//   rs1_ex, rs2_ex                   : EX sources (operand forwarding)
//   rd_ex/me/wb, regwrite_ex/me/wb   : destinations and write enables
//   rs2_me                           : ME store-data source
//   memread_ex, branch_taken_ex      : load in EX, redirect resolved in EX
//   mem_req_me, mem_ready_me         : data-memory handshake in ME
//   fwd_a, fwd_b, fwd_sd             : forwarding selects
//   stall_*, flush_*                 : pipeline register hold / bubble
//   mem_timeout                      : memory wait abandoned this cycle
//   cnt_load_use/mem_wait/flush      : saturating event counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int REG_NO = 32,
    parameter  int MEM_TO = 16,
    parameter  int CNT_W  = 32,
    localparam int AW     = $clog2(REG_NO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_id,
    input  logic [AW-1:0]    rs2_id,
    input  logic [AW-1:0]    rs1_ex,
    input  logic [AW-1:0]    rs2_ex,
    input  logic [AW-1:0]    rd_ex,
    input  logic [AW-1:0]    rd_me,
    input  logic [AW-1:0]    rd_wb,
    input  logic [AW-1:0]    rs2_me,
    input  logic             regwrite_ex,
    input  logic             regwrite_me,
    input  logic             regwrite_wb,
    input  logic             memread_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_req_me,
    input  logic             mem_ready_me,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_sd,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_me,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_mem_wait,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int            WW     = (MEM_TO > 2) ? $clog2(MEM_TO) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(MEM_TO - 1);

    state_t        state, state_nx;
    logic [WW-1:0] wcnt;
    logic          pend_flush;   // redirect seen while frozen, applied later
    logic          lu_hold;      // load-use stall already taken for this hazard
    logic          mem_stall;
    logic          load_use;
    logic          redirect;
    logic          lu_apply;

    // Load-use detection keys only on memread_ex; the EX write enable is not
    // needed for any decision here.
    logic          unused_regwrite_ex;
    assign unused_regwrite_ex = regwrite_ex;

    // ---------------------------------------------------------------- forwarding
    fwd_sel #(.AW(AW)) u_fwd_a (
        .rs          (rs1_ex),
        .rd_me       (rd_me),
        .regwrite_me (regwrite_me),
        .rd_wb       (rd_wb),
        .regwrite_wb (regwrite_wb),
        .sel         (fwd_a)
    );

    fwd_sel #(.AW(AW)) u_fwd_b (
        .rs          (rs2_ex),
        .rd_me       (rd_me),
        .regwrite_me (regwrite_me),
        .rd_wb       (rd_wb),
        .regwrite_wb (regwrite_wb),
        .sel         (fwd_b)
    );

    // Store data in ME can only be behind the WB writer.
    assign fwd_sd = regwrite_wb && (rd_wb != '0) && (rd_wb == rs2_me);

    // ------------------------------------------------------------ state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_nx = state;
        case (state)
            RUN:      if (mem_req_me && !mem_ready_me) state_nx = MEM_WAIT;
            MEM_WAIT: if (mem_ready_me || (wcnt == W_LAST)) state_nx = RUN;
            default:  state_nx = RUN;
        endcase
    end

    // ------------------------------------------------------------ outputs
    // NOTE: rst_n gates the combinational stall/flush decode so these outputs
    // are 0 during reset even though their inputs may still be active.
    always_comb begin
        mem_stall   = 1'b0;
        mem_timeout = 1'b0;
        redirect    = 1'b0;
        lu_apply    = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_me    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        load_use    = memread_ex && (rd_ex != '0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));
        if (rst_n) begin
            case (state)
                RUN: mem_stall = mem_req_me && !mem_ready_me;
                MEM_WAIT: begin
                    mem_stall   = !mem_ready_me && (wcnt < W_LAST);
                    mem_timeout = !mem_ready_me && (wcnt == W_LAST);
                end
                default: ;
            endcase
            redirect = !mem_stall && (branch_taken_ex || pend_flush);
            lu_apply = !mem_stall && !redirect && load_use && !lu_hold;
            stall_if = mem_stall || lu_apply;
            stall_id = mem_stall || lu_apply;
            stall_ex = mem_stall;
            stall_me = mem_stall;
            flush_id = redirect;
            flush_ex = redirect || lu_apply;
        end
    end

    // ------------------------------------------------------------ wait / pending
    // While the pipeline is frozen, EX cannot act on a redirect, so it is
    // remembered and issued on the first unfrozen cycle. lu_hold only advances
    // on unfrozen cycles, so a memory stall does not re-arm a finished
    // load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            pend_flush <= 1'b0;
            lu_hold    <= 1'b0;
        end else begin
            wcnt <= ((state == MEM_WAIT) && (state_nx == MEM_WAIT)) ? wcnt + WW'(1) : '0;
            if (mem_stall) begin
                pend_flush <= pend_flush || branch_taken_ex;
            end else begin
                pend_flush <= 1'b0;
                lu_hold    <= lu_apply;
            end
        end
    end

    // ------------------------------------------------------------ counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load_use <= '0;
            cnt_mem_wait <= '0;
            cnt_flush    <= '0;
        end else begin
            if (lu_apply)  cnt_load_use <= sat_inc(cnt_load_use);
            if (mem_stall) cnt_mem_wait <= sat_inc(cnt_mem_wait);
            if (redirect)  cnt_flush    <= sat_inc(cnt_flush);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl. Each driven cycle pushes the expected
// outputs computed by a cycle-level reference model; a negedge monitor pops
// and compares. Directed sequences cover the documented scenarios, then a
// randomized phase with varying memory-ready bias exercises timeouts and
// counter saturation (CNT_W is reduced so saturation is reachable).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int REG_NO = 32;
    localparam int MEM_TO = 16;
    localparam int CNT_W  = 6;
    localparam int AW     = 5;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb, rs2_me;
    logic             regwrite_ex, regwrite_me, regwrite_wb;
    logic             memread_ex, branch_taken_ex, mem_req_me, mem_ready_me;
    logic [1:0]       fwd_a, fwd_b;
    logic             fwd_sd, stall_if, stall_id, stall_ex, stall_me;
    logic             flush_id, flush_ex, mem_timeout;
    logic [CNT_W-1:0] cnt_load_use, cnt_mem_wait, cnt_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_NO(REG_NO), .MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb), .rs2_me(rs2_me),
        .regwrite_ex(regwrite_ex), .regwrite_me(regwrite_me), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
        .mem_req_me(mem_req_me), .mem_ready_me(mem_ready_me),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_sd(fwd_sd),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_me(stall_me),
        .flush_id(flush_id), .flush_ex(flush_ex), .mem_timeout(mem_timeout),
        .cnt_load_use(cnt_load_use), .cnt_mem_wait(cnt_mem_wait), .cnt_flush(cnt_flush)
    );

    typedef struct {
        logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb, rs2_me;
        bit rw_ex, rw_me, rw_wb, memread, br, req, rdy;
    } stim_t;

    typedef struct {
        int fa, fb, sd, sif, sid, sex, sme, fid, fex, tmo, clu, cmw, cfl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model state: length of the current memory wait in stalled
    // cycles (0 = not waiting), a redirect deferred by a freeze, whether the
    // last unfrozen cycle took a load-use stall, and event tallies.
    int m_waited, m_clu, m_cmw, m_cfl;
    bit m_pend, m_lu_recent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_waited = 0; m_pend = 0; m_lu_recent = 0;
        m_clu = 0; m_cmw = 0; m_cfl = 0;
    endfunction

    function automatic int ref_fwd(input stim_t s, input logic [AW-1:0] rs);
        if (s.rw_me && s.rd_me != 0 && s.rd_me == rs) return 2;
        if (s.rw_wb && s.rd_wb != 0 && s.rd_wb == rs) return 1;
        return 0;
    endfunction

    function automatic void model_push(input stim_t s);
        exp_t e;
        bit stall, tmo, redir, lu, lua;
        if (m_waited == 0) begin
            stall = s.req && !s.rdy;
            tmo   = 0;
        end else begin
            stall = !s.rdy && (m_waited < MEM_TO);
            tmo   = !s.rdy && (m_waited == MEM_TO);
        end
        redir = !stall && (s.br || m_pend);
        lu    = s.memread && s.rd_ex != 0 && (s.rd_ex == s.rs1_id || s.rd_ex == s.rs2_id);
        lua   = !stall && !redir && lu && !m_lu_recent;
        e.fa  = ref_fwd(s, s.rs1_ex);
        e.fb  = ref_fwd(s, s.rs2_ex);
        e.sd  = (s.rw_wb && s.rd_wb != 0 && s.rd_wb == s.rs2_me) ? 1 : 0;
        e.sif = int'(stall || lua);
        e.sid = int'(stall || lua);
        e.sex = int'(stall);
        e.sme = int'(stall);
        e.fid = int'(redir);
        e.fex = int'(redir || lua);
        e.tmo = int'(tmo);
        e.clu = m_clu; e.cmw = m_cmw; e.cfl = m_cfl;
        sb_q.push_back(e);
        if (stall) begin
            m_waited++;
            m_pend = m_pend || s.br;
        end else begin
            m_waited    = 0;
            m_pend      = 0;
            m_lu_recent = lua;
        end
        if (lua   && m_clu < CMAX) m_clu++;
        if (stall && m_cmw < CMAX) m_cmw++;
        if (redir && m_cfl < CMAX) m_cfl++;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rs1_id = '0; s.rs2_id = '0; s.rs1_ex = '0; s.rs2_ex = '0;
        s.rd_ex = '0; s.rd_me = '0; s.rd_wb = '0; s.rs2_me = '0;
        s.rw_ex = 0; s.rw_me = 0; s.rw_wb = 0; s.memread = 0;
        s.br = 0; s.req = 0; s.rdy = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim(input int bias);
        stim_t s;
        s.rs1_id = AW'($urandom_range(0, 3)); s.rs2_id = AW'($urandom_range(0, 3));
        s.rs1_ex = AW'($urandom_range(0, 3)); s.rs2_ex = AW'($urandom_range(0, 3));
        s.rd_ex  = AW'($urandom_range(0, 3)); s.rd_me  = AW'($urandom_range(0, 3));
        s.rd_wb  = AW'($urandom_range(0, 3)); s.rs2_me = AW'($urandom_range(0, 3));
        s.rw_ex   = $urandom_range(0, 1) == 1;
        s.rw_me   = $urandom_range(0, 1) == 1;
        s.rw_wb   = $urandom_range(0, 1) == 1;
        s.memread = $urandom_range(0, 9) < 3;
        s.br      = $urandom_range(0, 9) == 0;
        s.req     = $urandom_range(0, 9) < 4;
        s.rdy     = $urandom_range(0, 9) < bias;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rs1_id = s.rs1_id; rs2_id = s.rs2_id; rs1_ex = s.rs1_ex; rs2_ex = s.rs2_ex;
        rd_ex = s.rd_ex; rd_me = s.rd_me; rd_wb = s.rd_wb; rs2_me = s.rs2_me;
        regwrite_ex = s.rw_ex; regwrite_me = s.rw_me; regwrite_wb = s.rw_wb;
        memread_ex = s.memread; branch_taken_ex = s.br;
        mem_req_me = s.req; mem_ready_me = s.rdy;
    endtask

    // One clock cycle: drive after the rising edge, record expectation, and
    // return just after the falling edge where the monitor has compared.
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        model_push(s);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(idle());
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("fwd_a",        32'(fwd_a),        mon_e.fa);
            check("fwd_b",        32'(fwd_b),        mon_e.fb);
            check("fwd_sd",       32'(fwd_sd),       mon_e.sd);
            check("stall_if",     32'(stall_if),     mon_e.sif);
            check("stall_id",     32'(stall_id),     mon_e.sid);
            check("stall_ex",     32'(stall_ex),     mon_e.sex);
            check("stall_me",     32'(stall_me),     mon_e.sme);
            check("flush_id",     32'(flush_id),     mon_e.fid);
            check("flush_ex",     32'(flush_ex),     mon_e.fex);
            check("mem_timeout",  32'(mem_timeout),  mon_e.tmo);
            check("cnt_load_use", 32'(cnt_load_use), mon_e.clu);
            check("cnt_mem_wait", 32'(cnt_mem_wait), mon_e.cmw);
            check("cnt_flush",    32'(cnt_flush),    mon_e.cfl);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        int pulses;

        // Reset state, with forwarding still live during reset.
        rst_n = 1'b0;
        apply(idle());
        model_reset();
        mem_req_me = 1'b1;
        #12;
        check("rst_stall_if", 32'(stall_if), 0);
        check("rst_stall_me", 32'(stall_me), 0);
        check("rst_cnt_mem_wait", 32'(cnt_mem_wait), 0);
        rd_me = 5; regwrite_me = 1'b1; rs1_ex = 5;
        #1;
        check("rst_fwd_a", 32'(fwd_a), 2);
        apply(idle());
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding priority.
        s = idle();
        s.rd_me = 5; s.rd_wb = 5; s.rw_me = 1; s.rw_wb = 1; s.rs1_ex = 5; s.rs2_me = 5;
        step(s);
        check("dir_fwd_a_me", 32'(fwd_a), 2);
        check("dir_fwd_sd", 32'(fwd_sd), 1);
        s.rw_me = 0;
        step(s);
        check("dir_fwd_a_wb", 32'(fwd_a), 1);
        s.rw_me = 1; s.rd_me = 0; s.rd_wb = 0;
        step(s);
        check("dir_fwd_a_rf", 32'(fwd_a), 0);

        // Load-use: one stall cycle even with the hazard inputs held.
        do_reset();
        s = idle();
        s.memread = 1; s.rd_ex = 3; s.rs2_id = 3; s.rw_ex = 1;
        step(s);
        check("lu_stall_if", 32'(stall_if), 1);
        check("lu_flush_ex", 32'(flush_ex), 1);
        check("lu_stall_ex", 32'(stall_ex), 0);
        step(s);
        check("lu_once", 32'(stall_if), 0);
        check("lu_cnt", 32'(cnt_load_use), 1);
        step(idle());

        // Memory wait of four cycles.
        do_reset();
        s = idle();
        s.req = 1;
        for (int i = 0; i < 4; i++) begin
            step(s);
            check("mw_stall", 32'(stall_id), 1);
        end
        s.rdy = 1;
        step(s);
        check("mw_release", 32'(stall_me), 0);
        check("mw_cnt", 32'(cnt_mem_wait), 4);
        s = idle();
        s.req = 1; s.rdy = 1;
        step(s);
        check("mw_run", 32'(stall_if), 0);

        // Redirect during a memory stall is deferred to the release cycle.
        do_reset();
        s = idle();
        s.req = 1; s.br = 1;
        step(s);
        check("bf_frozen", 32'(flush_id), 0);
        s.br = 0;
        step(s);
        s.rdy = 1;
        step(s);
        check("bf_flush_id", 32'(flush_id), 1);
        check("bf_flush_ex", 32'(flush_ex), 1);
        step(idle());
        check("bf_once", 32'(flush_id), 0);
        check("bf_cnt", 32'(cnt_flush), 1);

        // Timeout after MEM_TO stalled cycles.
        do_reset();
        s = idle();
        s.req = 1;
        pulses = 0;
        for (int i = 0; i < MEM_TO; i++) begin
            step(s);
            check("to_stall", 32'(stall_me), 1);
            if (mem_timeout) pulses++;
        end
        step(s);
        check("to_pulse", 32'(mem_timeout), 1);
        check("to_stall_drop", 32'(stall_if), 0);
        check("to_cnt", 32'(cnt_mem_wait), MEM_TO);
        step(idle());
        check("to_single", 32'(mem_timeout), 0);
        check("to_early", 32'(pulses), 0);

        // Randomized traffic with a varying memory-ready bias.
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 200; i++) begin
                step(rand_stim((blk * 3) % 10));
            end
        end

        // Reset in the middle of a memory wait.
        do_reset();
        s = idle();
        s.req = 1;
        repeat (5) step(s);
        rst_n = 1'b0;
        #1;
        check("rw_stall_if", 32'(stall_if), 0);
        check("rw_flush_ex", 32'(flush_ex), 0);
        check("rw_timeout", 32'(mem_timeout), 0);
        check("rw_cnt_mem_wait", 32'(cnt_mem_wait), 0);
        check("rw_cnt_flush", 32'(cnt_flush), 0);
        model_reset();
        pulses = 0;
        for (int i = 0; i < MEM_TO + 4; i++) begin
            @(negedge clk);
            if (mem_timeout || stall_if) pulses++;
        end
        check("rw_no_pulse", 32'(pulses), 0);
        apply(idle());
        @(negedge clk);
        rst_n = 1'b1;
        step(idle());
        check("rw_after", 32'(cnt_mem_wait), 0);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
